predict_sequencer: RTL

PREDICT_SEQUENCER -- requirements
Module: predict_sequencer

---
 rtl/predict_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/predict_sequencer.sv
// predict_sequencer
//   Assembles a 7x7 binary image from a raster pixel stream, holds the
//   classifier enabled for SETTLE cycles, then captures its result and
//   filters it through a VOTE_N-deep majority-free (all-equal) vote.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   frame_start  marks the current pix_valid beat as pixel 0
//   pix_valid    pixel beat strobe
//   pix_data     binary pixel, raster order
//   img[48:0]    assembled frame, pixel k = row*7+col on img[k]
//   cls_enable   classifier enable (high only in EVAL)
//   cls_digit    classifier result
//   raw_digit    most recent captured result
//   digit        vote-filtered result, 4'hF until first stable vote
//   digit_valid  one-cycle pulse per completed classification
//   stable       last VOTE_N results identical
//   busy         high in EVAL and REPORT
//   overrun      one-cycle pulse after a dropped pix_valid beat
module predict_sequencer #(
    parameter int SETTLE = 1,
    parameter int VOTE_N = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic        pix_data,
    output logic [48:0] img,
    output logic        cls_enable,
    input  logic [3:0]  cls_digit,
    output logic [3:0]  raw_digit,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        stable,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, LOAD, EVAL, REPORT} state_t;

    state_t            state;
    logic [5:0]        count;
    logic [3:0]        settle_cnt;
    logic [3:0]        fill;
    logic [3:0]        fill_next;
    logic [3:0]        hist [VOTE_N];
    logic [VOTE_N-1:0] match;
    logic              capture;

    // Capture happens on the edge that ends the final EVAL cycle.
    assign capture   = (state == EVAL) && (settle_cnt == 4'(SETTLE - 1));
    assign fill_next = (fill == 4'(VOTE_N)) ? fill : fill + 4'd1;

    // History shift register; hist[0] is the newest result. match[gi]
    // compares the entry that will sit at position gi after the shift
    // against the incoming result (position 0 is the result itself).
    for (genvar gi = 0; gi < VOTE_N; gi++) begin : g_hist
        if (gi == 0) begin : g_head
            assign match[gi] = 1'b1;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)        hist[gi] <= 4'd0;
                else if (capture) hist[gi] <= cls_digit;
            end
        end else begin : g_tail
            assign match[gi] = (hist[gi-1] == cls_digit);
            always_ff @(posedge clk or posedge reset) begin
                if (reset)        hist[gi] <= 4'd0;
                else if (capture) hist[gi] <= hist[gi-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 6'd0;
            img         <= '0;
            settle_cnt  <= 4'd0;
            fill        <= 4'd0;
            cls_enable  <= 1'b0;
            raw_digit   <= 4'd0;
            digit       <= 4'hF;
            digit_valid <= 1'b0;
            stable      <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= pix_valid && ((state == EVAL) || (state == REPORT));
            case (state)
                IDLE: begin
                    if (pix_valid && frame_start) begin
                        img[0] <= pix_data;
                        count  <= 6'd1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (pix_valid) begin
                        if (frame_start) begin
                            // Restart: older bits are left in place and get overwritten.
                            img[0] <= pix_data;
                            count  <= 6'd1;
                        end else begin
                            img[count] <= pix_data;
                            if (count == 6'd48) begin
                                state      <= EVAL;
                                count      <= 6'd0;
                                settle_cnt <= 4'd0;
                                cls_enable <= 1'b1;
                                busy       <= 1'b1;
                            end else begin
                                count <= count + 6'd1;
                            end
                        end
                    end
                end
                EVAL: begin
                    if (capture) begin
                        raw_digit   <= cls_digit;
                        fill        <= fill_next;
                        if ((fill_next == 4'(VOTE_N)) && (&match)) begin
                            digit  <= cls_digit;
                            stable <= 1'b1;
                        end else begin
                            stable <= 1'b0;
                        end
                        cls_enable  <= 1'b0;
                        digit_valid <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                REPORT: begin
                    digit_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
